// File: rtl/mmio_pkg.sv
// Shared types for the MMIO slot initiator: FSM states, response codes and bus widths.
package mmio_pkg;

    localparam int DATA_W   = 32;
    localparam int OFFSET_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2,
        RESP     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_SLAVE   = 2'b01,
        RSP_DECODE  = 2'b10,
        RSP_TIMEOUT = 2'b11
    } rsp_err_t;

endpackage

// File: rtl/mmio_slot_initiator_if.sv
// Host request/response channel plus the shared slot bus, bundled for the initiator.
interface mmio_slot_initiator_if #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_BITS = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [SLOT_BITS+7:0]    req_addr;
    logic [31:0]             req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_rdata;
    logic [1:0]              rsp_err;
    logic [NUM_SLOTS-1:0]    chip_select;
    logic                    read;
    logic                    write;
    logic [7:0]              addr;
    logic [31:0]             wr_data;
    logic                    transaction_completed;
    logic [NUM_SLOTS*32-1:0] slot_rd_data;
    logic [NUM_SLOTS-1:0]    slot_wr_done;
    logic [NUM_SLOTS-1:0]    slot_rd_done;
    logic [NUM_SLOTS-1:0]    slot_slave_error;
    logic [NUM_SLOTS-1:0]    slot_decode_error;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  slot_rd_data, slot_wr_done, slot_rd_done, slot_slave_error, slot_decode_error,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output chip_select, read, write, addr, wr_data, transaction_completed
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output slot_rd_data, slot_wr_done, slot_rd_done, slot_slave_error, slot_decode_error,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  chip_select, read, write, addr, wr_data, transaction_completed
    );
endinterface

// File: rtl/mmio_slot_mux.sv
// Picks done/error/read-data of the currently addressed slot; all other slots are masked off.
module mmio_slot_mux
    import mmio_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_BITS = 4
) (
    input  logic [SLOT_BITS-1:0]        idx,
    input  logic [NUM_SLOTS*DATA_W-1:0] slot_rd_data,
    input  logic [NUM_SLOTS-1:0]        slot_wr_done,
    input  logic [NUM_SLOTS-1:0]        slot_rd_done,
    input  logic [NUM_SLOTS-1:0]        slot_slave_error,
    input  logic [NUM_SLOTS-1:0]        slot_decode_error,
    output logic                        done,
    output logic                        slave_err,
    output logic                        decode_err,
    output logic [DATA_W-1:0]           rd_data
);

    logic [NUM_SLOTS-1:0] hit;
    logic [DATA_W-1:0]    masked [NUM_SLOTS];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign hit[gi]    = (idx == SLOT_BITS'(gi));
            assign masked[gi] = slot_rd_data[gi*DATA_W +: DATA_W] & {DATA_W{hit[gi]}};
        end
    endgenerate

    assign done       = |(hit & (slot_wr_done | slot_rd_done));
    assign slave_err  = |(hit & slot_slave_error);
    assign decode_err = |(hit & slot_decode_error);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rd_data = rd_data | masked[i];
        end
    end

endmodule

// File: rtl/mmio_slot_initiator.sv
// Single-outstanding MMIO initiator: decodes a host request to a slot, runs the
// select/strobe access with a timeout, and returns read data with an error code.
module mmio_slot_initiator
    import mmio_pkg::*;
#(
    parameter int NUM_SLOTS      = 8,
    parameter int SLOT_BITS      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_slot_initiator_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t                state_reg;
    logic [SLOT_BITS-1:0]  idx_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [NUM_SLOTS-1:0]  cs_reg;
    logic                  read_reg;
    logic                  write_reg;
    logic [OFFSET_W-1:0]   addr_reg;
    logic [DATA_W-1:0]     wr_data_reg;
    logic                  rsp_valid_reg;
    logic [DATA_W-1:0]     rsp_rdata_reg;
    rsp_err_t              rsp_err_reg;
    logic                  tc_reg;

    logic [SLOT_BITS-1:0]  req_slot;
    logic                  req_in_range;
    logic                  sel_done;
    logic                  sel_slave_err;
    logic                  sel_decode_err;
    logic [DATA_W-1:0]     sel_rd_data;
    logic                  timeout_hit;
    rsp_err_t              rsp_err_next;

    assign req_slot     = bus.req_addr[SLOT_BITS+7:8];
    assign req_in_range = int'(req_slot) < NUM_SLOTS;
    assign timeout_hit  = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    mmio_slot_mux #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_BITS (SLOT_BITS)
    ) u_mux (
        .idx               (idx_reg),
        .slot_rd_data      (bus.slot_rd_data),
        .slot_wr_done      (bus.slot_wr_done),
        .slot_rd_done      (bus.slot_rd_done),
        .slot_slave_error  (bus.slot_slave_error),
        .slot_decode_error (bus.slot_decode_error),
        .done              (sel_done),
        .slave_err         (sel_slave_err),
        .decode_err        (sel_decode_err),
        .rd_data           (sel_rd_data)
    );

    // Error lines are only meaningful in the cycle the selected slot reports done.
    always_comb begin
        rsp_err_next = RSP_OK;
        if (sel_decode_err) begin
            rsp_err_next = RSP_DECODE;
        end else if (sel_slave_err) begin
            rsp_err_next = RSP_SLAVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            count_reg     <= '0;
            cs_reg        <= '0;
            read_reg      <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wr_data_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= RSP_OK;
            tc_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_in_range) begin
                            state_reg   <= ACCESS;
                            idx_reg     <= req_slot;
                            count_reg   <= '0;
                            cs_reg      <= NUM_SLOTS'(1) << req_slot;
                            read_reg    <= ~bus.req_write;
                            write_reg   <= bus.req_write;
                            addr_reg    <= bus.req_addr[7:0];
                            wr_data_reg <= bus.req_wdata;
                        end else begin
                            // Out-of-range slot: answer locally, the bus stays quiet.
                            state_reg     <= COMPLETE;
                            rsp_valid_reg <= 1'b1;
                            rsp_rdata_reg <= '0;
                            rsp_err_reg   <= RSP_DECODE;
                            tc_reg        <= 1'b0;
                        end
                    end
                end

                ACCESS: begin
                    if (sel_done) begin
                        state_reg     <= COMPLETE;
                        cs_reg        <= '0;
                        read_reg      <= 1'b0;
                        write_reg     <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= rsp_err_next;
                        rsp_rdata_reg <= (read_reg && rsp_err_next == RSP_OK) ? sel_rd_data : '0;
                        tc_reg        <= 1'b1;
                    end else if (timeout_hit) begin
                        state_reg     <= COMPLETE;
                        cs_reg        <= '0;
                        read_reg      <= 1'b0;
                        write_reg     <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= RSP_TIMEOUT;
                        rsp_rdata_reg <= '0;
                        tc_reg        <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end

                COMPLETE: begin
                    tc_reg <= 1'b0;
                    if (bus.rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= RSP_OK;
                    end else begin
                        state_reg <= RESP;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= RSP_OK;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // Gated by rst so the host never sees ready while reset is held.
    assign bus.req_ready             = (state_reg == IDLE) && !rst;
    assign bus.rsp_valid             = rsp_valid_reg;
    assign bus.rsp_rdata             = rsp_rdata_reg;
    assign bus.rsp_err               = rsp_err_reg;
    assign bus.chip_select           = cs_reg;
    assign bus.read                  = read_reg;
    assign bus.write                 = write_reg;
    assign bus.addr                  = addr_reg;
    assign bus.wr_data               = wr_data_reg;
    assign bus.transaction_completed = tc_reg;

endmodule

// File: tb/tb_mmio_slot_initiator.sv
// Directed bench: slot 0 timer model, slot 1 dead, slot 2 answers on the last legal
// cycle, slot 3 answers at once with error lines, slot 4 always noisy but never selected.
module tb_mmio_slot_initiator;

    localparam int NS = 8;
    localparam int SB = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_slot_initiator_if #(.NUM_SLOTS(NS), .SLOT_BITS(SB)) bus ();

    mmio_slot_initiator #(
        .NUM_SLOTS      (NS),
        .SLOT_BITS      (SB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Slot models
    logic [31:0] timer_reg;
    logic        sel0_d;
    int          cnt2;

    always @(posedge clk) begin
        if (rst) begin
            timer_reg <= 32'h0;
            sel0_d    <= 1'b0;
            cnt2      <= 0;
        end else begin
            sel0_d <= bus.chip_select[0];
            cnt2   <= bus.chip_select[2] ? cnt2 + 1 : 0;
            if (bus.chip_select[0] && sel0_d && bus.write && bus.addr == 8'h04)
                timer_reg <= bus.wr_data;
        end
    end

    always_comb begin
        logic d0;
        bus.slot_wr_done      = '0;
        bus.slot_rd_done      = '0;
        bus.slot_slave_error  = '0;
        bus.slot_decode_error = '0;
        bus.slot_rd_data      = '0;
        d0 = bus.chip_select[0] & sel0_d;
        bus.slot_wr_done[0]      = d0 & bus.write;
        bus.slot_rd_done[0]      = d0 & bus.read;
        bus.slot_decode_error[0] = (bus.addr != 8'h00) && (bus.addr != 8'h04);
        bus.slot_slave_error[0]  = bus.write && (bus.addr == 8'h00);
        bus.slot_rd_data[31:0]   = (bus.addr == 8'h00) ? 32'h0001_0000 :
                                   (bus.addr == 8'h04) ? timer_reg : 32'h0;
        bus.slot_rd_done[2]      = bus.chip_select[2] && (cnt2 == TO - 1);
        bus.slot_rd_data[95:64]  = 32'h5A5A_0000 | {24'h0, bus.addr};
        bus.slot_wr_done[3]      = bus.chip_select[3] & bus.write;
        bus.slot_rd_done[3]      = bus.chip_select[3] & bus.read;
        bus.slot_decode_error[3] = (bus.addr == 8'hFF);
        bus.slot_slave_error[3]  = (bus.addr >= 8'hFE);
        bus.slot_rd_data[127:96] = 32'hCAFE_0000 | {24'h0, bus.addr};
        bus.slot_wr_done[4]      = 1'b1;
        bus.slot_rd_done[4]      = 1'b1;
        bus.slot_slave_error[4]  = 1'b1;
        bus.slot_decode_error[4] = 1'b1;
        bus.slot_rd_data[159:128] = 32'hDEAD_BEEF;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cs;
        int          tc;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d);
        int k;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int cyc, cs_cnt, tc_cnt, bad;
        logic [31:0] rd;
        logic [1:0]  er;
        cyc = 0; cs_cnt = 0; tc_cnt = 0; bad = 0;
        issue(v.w, v.a, v.d);
        do begin
            @(negedge clk);
            cyc++;
            if (bus.chip_select != '0) begin
                cs_cnt++;
                if (bus.chip_select != (8'd1 << v.a[11:8]) || bus.write != v.w ||
                    bus.read != !v.w || bus.addr != v.a[7:0] ||
                    (v.w && bus.wr_data != v.d))
                    bad++;
            end
            if (bus.transaction_completed) tc_cnt++;
        end while (!bus.rsp_valid && cyc < 200);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(negedge clk);
        if (bus.transaction_completed) tc_cnt++;
        check($sformatf("v%0d_err", i),   {30'h0, er}, {30'h0, v.err});
        check($sformatf("v%0d_rdata", i), rd, v.rdata);
        check($sformatf("v%0d_cs_cycles", i), cs_cnt, v.cs);
        check($sformatf("v%0d_tc_pulses", i), tc_cnt, v.tc);
        check($sformatf("v%0d_latency", i), cyc, v.lat);
        check($sformatf("v%0d_strobes", i), bad, 0);
        $display("txn %0d: %s addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d cs=%0d tc=%0d lat=%0d",
                 i, v.w ? "W" : "R", v.a, v.d, rd, er, cs_cnt, tc_cnt, cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        vecs[0]  = '{1'b1, 12'h004, 32'h0000_1234, 32'h0,          2'b00, 2,  1, 3};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,         32'h0000_1234,  2'b00, 2,  1, 3};
        vecs[2]  = '{1'b1, 12'h000, 32'h0000_FFFF, 32'h0,          2'b01, 2,  1, 3};
        vecs[3]  = '{1'b0, 12'h000, 32'h0,         32'h0001_0000,  2'b00, 2,  1, 3};
        vecs[4]  = '{1'b0, 12'h020, 32'h0,         32'h0,          2'b10, 2,  1, 3};
        vecs[5]  = '{1'b0, 12'h904, 32'h0,         32'h0,          2'b10, 0,  0, 1};
        vecs[6]  = '{1'b1, 12'hF00, 32'h1111_2222, 32'h0,          2'b10, 0,  0, 1};
        vecs[7]  = '{1'b0, 12'h800, 32'h0,         32'h0,          2'b10, 0,  0, 1};
        vecs[8]  = '{1'b0, 12'h110, 32'h0,         32'h0,          2'b11, 64, 1, 65};
        vecs[9]  = '{1'b0, 12'h004, 32'h0,         32'h0000_1234,  2'b00, 2,  1, 3};
        vecs[10] = '{1'b0, 12'h30C, 32'h0,         32'hCAFE_000C,  2'b00, 1,  1, 2};
        vecs[11] = '{1'b1, 12'h30C, 32'h0000_0005, 32'h0,          2'b00, 1,  1, 2};
        vecs[12] = '{1'b0, 12'h3FF, 32'h0,         32'h0,          2'b10, 1,  1, 2};
        vecs[13] = '{1'b0, 12'h3FE, 32'h0,         32'h0,          2'b01, 1,  1, 2};
        vecs[14] = '{1'b0, 12'h208, 32'h0,         32'h5A5A_0008,  2'b00, 64, 1, 65};
        vecs[15] = '{1'b1, 12'h104, 32'h0000_00AA, 32'h0,          2'b11, 64, 1, 65};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("rst_chip_select", {24'h0, bus.chip_select}, 32'h0);
        check("rst_tc", {31'h0, bus.transaction_completed}, 32'h0);
        check("rst_strobes", {30'h0, bus.read, bus.write}, 32'h0);
        check("rst_rsp_err", {30'h0, bus.rsp_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Backpressure: response held for several cycles
        bus.rsp_ready = 1'b0;
        issue(1'b0, 12'h004, 32'h0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.rsp_valid && cyc < 20);
        check("bp_latency", cyc, 3);
        check("bp_first_tc", {31'h0, bus.transaction_completed}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'h0000_1234);
            check("bp_rsp_err", {30'h0, bus.rsp_err}, 32'h0);
            check("bp_req_ready", {31'h0, bus.req_ready}, 32'h0);
            if (k > 0) check("bp_tc_low", {31'h0, bus.transaction_completed}, 32'h0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("bp_released_ready", {31'h0, bus.req_ready}, 32'h1);
        $display("txn bp: R addr=0x004 held 5 cycles, released");

        // Reset in the middle of an access to the dead slot
        issue(1'b1, 12'h110, 32'hA5A5_5A5A);
        repeat (5) @(negedge clk);
        check("mid_access_cs", {24'h0, bus.chip_select}, 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", {24'h0, bus.chip_select}, 32'h0);
        check("abort_strobes", {30'h0, bus.read, bus.write}, 32'h0);
        check("abort_addr", {24'h0, bus.addr}, 32'h0);
        check("abort_wr_data", bus.wr_data, 32'h0);
        check("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("abort_tc", {31'h0, bus.transaction_completed}, 32'h0);
        check("abort_req_ready", {31'h0, bus.req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("after_abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("after_abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        $display("txn rst: W addr=0x110 aborted by reset");

        // Timer register was cleared by the same reset
        run_vec(16, '{1'b0, 12'h004, 32'h0, 32'h0, 2'b00, 2, 1, 3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
